// File: rtl/testbasic9_source_pkg.sv
// Shared types and constants for the TestBasic9 source block.
//   TestBasic9Source_SECTIONS : FSM state encoding (READ_S, WRITE_S)
//   SAT_MAX / SAT_MIN         : clamp limits used when the adder saturates
package testbasic9_source_types;
  typedef enum logic {READ_S = 1'b0, WRITE_S = 1'b1} TestBasic9Source_SECTIONS;
  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;
endpackage

// File: rtl/testbasic9_source_if.sv
// Handshake bundle between testbasic9_source, its producer and its consumer.
//   a_in / a_in_sync / a_in_notify    : blocking input port (data, valid, ready)
//   b_out / b_out_sync / b_out_notify : blocking output port (data, ready, valid)
//   m_out                             : running transfer tally
// modport master : seen by the source block (drives notify, b_out, m_out)
// modport slave  : seen by the surrounding producer/consumer
interface testbasic9_source_if;
  logic signed [31:0] a_in;
  logic               a_in_sync;
  logic               a_in_notify;
  logic signed [31:0] b_out;
  logic               b_out_sync;
  logic               b_out_notify;
  logic        [31:0] m_out;

  modport master (
    input  a_in, a_in_sync, b_out_sync,
    output a_in_notify, b_out, b_out_notify, m_out
  );
  modport slave (
    output a_in, a_in_sync, b_out_sync,
    input  a_in_notify, b_out, b_out_notify, m_out
  );
endinterface

// File: rtl/testbasic9_source_add.sv
// Combinational signed 32-bit adder for the accumulator.
//   a, b : signed operands
//   sum  : a + b, wrapping by default
// Macro TESTBASIC9_SOURCE_SAT_EN: clamp to SAT_MAX / SAT_MIN on overflow.
module testbasic9_source_add
  import testbasic9_source_types::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] sum
);
  logic signed [31:0] w_raw;

  assign w_raw = a + b;

`ifdef TESTBASIC9_SOURCE_SAT_EN
  // Overflow only when both operands share a sign the result does not.
  logic w_ovf;
  assign w_ovf = (a[31] == b[31]) && (w_raw[31] != a[31]);
  always_comb begin
    sum = w_raw;
    if (w_ovf) sum = a[31] ? SAT_MIN : SAT_MAX;
  end
`else
  assign sum = w_raw;
`endif
endmodule

// File: rtl/testbasic9_source.sv
// Upstream producer for TestBasic9: accumulates a_in samples and offers each
// new accumulator value on b_out; m_out counts completed b_out transfers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : testbasic9_source_if.master (a_in/b_out handshakes, m_out)
// Parameters: INIT_VAL (accumulator reset/restart), STEP (m_out increment).
// Macro TESTBASIC9_SOURCE_SAT_EN selects a saturating accumulator add.
module testbasic9_source
  import testbasic9_source_types::*;
#(
  parameter logic signed [31:0] INIT_VAL = 32'sd1337,
  parameter logic        [31:0] STEP     = 32'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  testbasic9_source_if.master        bus
);
  TestBasic9Source_SECTIONS r_state, w_state;
  logic signed [31:0] r_acc, w_acc;
  logic signed [31:0] r_b_out, w_b_out;
  logic        [31:0] r_m_out, w_m_out;
  logic               r_a_notify, w_a_notify;
  logic               r_b_notify, w_b_notify;

  logic               w_a_xfer, w_b_xfer;
  logic signed [31:0] w_sum, w_next;

  // Notify is registered, so sync only ever affects next-cycle state.
  assign w_a_xfer = r_a_notify & bus.a_in_sync;
  assign w_b_xfer = r_b_notify & bus.b_out_sync;

  testbasic9_source_add u_add (
    .a   (r_acc),
    .b   (bus.a_in),
    .sum (w_sum)
  );

  // A zero sample restarts the accumulator instead of adding.
  assign w_next = (bus.a_in == 32'sd0) ? INIT_VAL : w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= READ_S;
      r_acc      <= INIT_VAL;
      r_b_out    <= '0;
      r_m_out    <= '0;
      r_a_notify <= 1'b1;
      r_b_notify <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_acc      <= w_acc;
      r_b_out    <= w_b_out;
      r_m_out    <= w_m_out;
      r_a_notify <= w_a_notify;
      r_b_notify <= w_b_notify;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_acc      = r_acc;
    w_b_out    = r_b_out;
    w_m_out    = r_m_out;
    w_a_notify = r_a_notify;
    w_b_notify = r_b_notify;
    case (r_state)
      READ_S: begin
        if (w_a_xfer) begin
          w_acc      = w_next;
          w_b_out    = w_next;
          w_a_notify = 1'b0;
          w_b_notify = 1'b1;
          w_state    = WRITE_S;
        end
      end
      WRITE_S: begin
        if (w_b_xfer) begin
          w_b_notify = 1'b0;
          w_a_notify = 1'b1;
          w_m_out    = r_m_out + STEP;
          w_state    = READ_S;
        end
      end
      default: w_state = READ_S;
    endcase
  end

  assign bus.a_in_notify  = r_a_notify;
  assign bus.b_out_notify = r_b_notify;
  assign bus.b_out        = r_b_out;
  assign bus.m_out        = r_m_out;
endmodule
